pulse_issue_scheduler: RTL and testbench
========================================

PULSE_ISSUE_SCHEDULER -- requirements
Module: pulse_issue_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of slow-domain requesters (2..8).
REQ-002 The block SHALL have parameter CNT_W, default 3, giving the per-requester pending-counter width.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2, giving the mandatory idle slow cycles after each issued pulse (legal range 1..15).
REQ-004 The block SHALL have port slow_clk  input  1  sole clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_pulse  input  NUM_REQ  per-requester single-cycle event strobes.
REQ-007 The block SHALL have port enable  input  1  when high, new issues are allowed.
REQ-008 The block SHALL have port ovf_clr  input  1  clears all sticky overflow flags.
REQ-009 The block SHALL have port pulse_slow_out  output  1  single-cycle pulse that drives the slow-to-fast pulse synchronizer input.
REQ-010 The block SHALL have port grant_id  output  clog2(NUM_REQ)  index of the requester served by the most recent pulse.
REQ-011 The block SHALL have port overflow  output  NUM_REQ  sticky per-requester flag that sets when an event is dropped.
REQ-012 The block SHALL have port busy  output  1  high when the state is not IDLE or any pending count is nonzero.

Function
REQ-013 Each requester SHALL own a registered pending count that increments on req_pulse[i]; an arrival is visible to arbitration in the following cycle.
REQ-014 An arrival and an issue for the same requester in the same cycle SHALL leave that requester's count unchanged.
REQ-015 If the count equals 2^CNT_W-1 and an arrival occurs with no issue for that requester in the same cycle, the arrival SHALL be dropped and overflow[i] SHALL be set.
REQ-016 Arrival at maximum count together with an issue for the same requester SHALL NOT set overflow.
REQ-017 ovf_clr SHALL clear all overflow bits; if ovf_clr and a new overflow occur in the same cycle, the new overflow SHALL win (bit set).
REQ-018 The FSM SHALL have two states, IDLE and GAP.
REQ-019 In IDLE, with enable=1 and any count nonzero, the block SHALL select a winner by round-robin starting at the priority pointer.
REQ-020 When a winner is selected, the block SHALL, in the next cycle, drive pulse_slow_out=1 for exactly one cycle, load grant_id with the winner, decrement the winner's count, set the pointer to (winner+1) mod NUM_REQ, and enter GAP.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles with pulse_slow_out=0, then return to IDLE.
REQ-022 The minimum spacing between issued pulses SHALL be GAP_CYCLES+1 cycles (rising edge to rising edge).
REQ-023 grant_id SHALL be updated only on the cycle the pulse is asserted and SHALL remain stable until the next issue.
REQ-024 enable=0 SHALL block new issues; any GAP in progress SHALL complete; counts SHALL keep accumulating while issues are blocked.
REQ-025 Issue latency SHALL be 2 cycles (arrival cycle, then arbitration in IDLE, then pulse) when the block is idle and has no backlog.

Reset
REQ-026 Assertion of rst_n SHALL immediately force pulse_slow_out=0, grant_id=0, overflow=0, busy=0, all counts=0, pointer=0, and state=IDLE, including mid-GAP.
REQ-027 The first rising edge after deassertion SHALL sample req_pulse normally.

Structure
REQ-028 Shared package pulse_sched_pkg SHALL hold the state encoding (IDLE=0, GAP=1) and the ID-width helper function.
REQ-029 The round-robin selection SHALL be implemented in a combinational sub-module rr_arbiter with inputs request vector and pointer, and outputs valid and winner index.
REQ-030 No logic in this block SHALL run on fast_clk.

Verification
REQ-031 The bench SHALL check the single request: req_pulse=4'b0001 at cycle 0 -> pulse_slow_out high at cycle 2 only, grant_id=0, busy low from cycle 5.
REQ-032 The bench SHALL check simultaneous requests: req_pulse=4'b1111 in one cycle -> four pulses at cycles 2, 5, 8 and 11 with grant_id 0, 1, 2, 3.
REQ-033 The bench SHALL check overflow: 8 pulses on req 2 with enable=0 -> count saturates at 7 and overflow=4'b0100; then ovf_clr -> overflow=0; then enable=1 -> exactly 7 pulses with grant_id=2.
REQ-034 The bench SHALL check fairness: req 0 strobed every cycle and req 3 strobed once -> grant_id=3 is issued within 2 pulses of its arrival.
REQ-035 The bench SHALL check reset during GAP: rst_n low one cycle after a pulse -> all outputs 0 asynchronously, and the pending backlog is lost.
REQ-036 The bench SHALL check the synchronizer integration: connect to the slow-to-fast pulse synchronizer with fast_clk at 4x slow_clk -> exactly one fast-domain pulse per issued slow pulse, with no merging at the minimum gap.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// rtl/pulse_sched_pkg.sv - shared state encoding and ID-width helper for the pulse issue scheduler
package pulse_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } sched_state_t;

    // A single requester still gets a 1-bit grant index.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pulse_issue_scheduler_rr_arbiter.sv
// rtl/pulse_issue_scheduler_rr_arbiter.sv - combinational round-robin pick starting at the priority pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [ID_W-1:0]    winner
);

    always_comb begin
        int idx;
        idx    = 0;
        valid  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pulse_issue_scheduler.sv
// rtl/pulse_issue_scheduler.sv - counts requester strobes and issues spaced single-cycle pulses round-robin
module pulse_issue_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int CNT_W      = 3,
    parameter int GAP_CYCLES = 2
) (
    input  logic                            slow_clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_pulse,
    input  logic                            enable,
    input  logic                            ovf_clr,
    output logic                            pulse_slow_out,
    output logic [id_width(NUM_REQ)-1:0]    grant_id,
    output logic [NUM_REQ-1:0]              overflow,
    output logic                            busy
);

    localparam int ID_W = id_width(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    sched_state_t                    state, state_nxt;
    logic [3:0]                      gap_cnt;
    logic [NUM_REQ-1:0][CNT_W-1:0]   counts;
    logic [NUM_REQ-1:0]              pending;
    logic [NUM_REQ-1:0]              issue_vec;
    logic [NUM_REQ-1:0]              ovf_set;
    logic [ID_W-1:0]                 ptr, winner;
    logic                            win_valid, issue;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req    (pending),
        .ptr    (ptr),
        .valid  (win_valid),
        .winner (winner)
    );

    // The pulse cycle itself is the first GAP cycle, so the counter starts at GAP_CYCLES-1.
    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                gap_cnt <= 4'(GAP_CYCLES - 1);
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue) state_nxt = GAP;
            GAP:  if (gap_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue = (state == IDLE) && enable && win_valid;
        busy  = (state != IDLE) || (|pending);
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pending[i]   = |counts[i];
            issue_vec[i] = issue && (winner == ID_W'(i));
            ovf_set[i]   = req_pulse[i] && !issue_vec[i] && (counts[i] == CNT_MAX);
        end
    end

    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_slow_out <= 1'b0;
            grant_id       <= '0;
            ptr            <= '0;
            counts         <= '0;
            overflow       <= '0;
        end else begin
            pulse_slow_out <= issue;
            if (issue) begin
                grant_id <= winner;
                ptr      <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_pulse[i] && !issue_vec[i]) begin
                    if (counts[i] != CNT_MAX) begin
                        counts[i] <= counts[i] + 1'b1;
                    end
                end else if (!req_pulse[i] && issue_vec[i]) begin
                    counts[i] <= counts[i] - 1'b1;
                end
            end
            // A fresh drop in the clearing cycle keeps its flag.
            overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
        end
    end

endmodule

// File: tb/tb_pulse_issue_scheduler.sv
// tb/tb_pulse_issue_scheduler.sv - directed self-checking bench for pulse_issue_scheduler
module tb_pulse_issue_scheduler;

    logic       slow_clk;
    logic       fast_clk;
    logic       rst_n;
    logic [3:0] req_pulse;
    logic       enable;
    logic       ovf_clr;
    logic       pulse_slow_out;
    logic [1:0] grant_id;
    logic [3:0] overflow;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic       pulse_log [0:31];
    logic [1:0] grant_log [0:31];
    logic       busy_log  [0:31];

    logic sync1, sync2, sync3;
    int   fast_cnt = 0;

    pulse_issue_scheduler #(
        .NUM_REQ    (4),
        .CNT_W      (3),
        .GAP_CYCLES (2)
    ) dut (
        .slow_clk       (slow_clk),
        .rst_n          (rst_n),
        .req_pulse      (req_pulse),
        .enable         (enable),
        .ovf_clr        (ovf_clr),
        .pulse_slow_out (pulse_slow_out),
        .grant_id       (grant_id),
        .overflow       (overflow),
        .busy           (busy)
    );

    initial begin
        slow_clk = 1'b0;
        forever #20 slow_clk = ~slow_clk;
    end

    initial begin
        fast_clk = 1'b0;
        #3;
        forever #5 fast_clk = ~fast_clk;
    end

    // Slow-to-fast pulse synchronizer: two flops then a rising-edge detect.
    always @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= pulse_slow_out;
            sync2 <= sync1;
            sync3 <= sync2;
            if (sync2 && !sync3) fast_cnt <= fast_cnt + 1;
        end
    end

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_pulse = '0;
        enable    = 1'b1;
        ovf_clr   = 1'b0;
        repeat (2) @(posedge slow_clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic capture(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge slow_clk);
            pulse_log[c] = pulse_slow_out;
            grant_log[c] = grant_id;
            busy_log[c]  = busy;
            @(posedge slow_clk);
            #1;
            req_pulse = '0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_pulse = '0; enable = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(posedge slow_clk);
        #1;
        n_cmp++; if (pulse_slow_out !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b expected 0", pulse_slow_out); end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        n_cmp++; if (overflow !== 4'b0000) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0000", overflow); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        apply_reset();
        req_pulse = 4'b0001;
        capture(8);
        for (int c = 0; c < 8; c++) begin
            n_cmp++;
            if (pulse_log[c] !== (c == 2)) begin
                n_bad++; $display("FAIL single_pulse cycle %0d: got %b expected %b", c, pulse_log[c], (c == 2));
            end
        end
        n_cmp++; if (grant_log[2] !== 2'd0) begin n_bad++; $display("FAIL single_grant: got %0d expected 0", grant_log[2]); end
        n_cmp++; if (busy_log[1] !== 1'b1) begin n_bad++; $display("FAIL single_busy_c1: got %b expected 1", busy_log[1]); end
        for (int c = 5; c < 8; c++) begin
            n_cmp++;
            if (busy_log[c] !== 1'b0) begin n_bad++; $display("FAIL single_busy cycle %0d: got %b expected 0", c, busy_log[c]); end
        end
    endtask

    task automatic test_simultaneous();
        logic exp_p;
        apply_reset();
        req_pulse = 4'b1111;
        capture(16);
        for (int c = 0; c < 16; c++) begin
            exp_p = (c == 2) || (c == 5) || (c == 8) || (c == 11);
            n_cmp++;
            if (pulse_log[c] !== exp_p) begin
                n_bad++; $display("FAIL simul_pulse cycle %0d: got %b expected %b", c, pulse_log[c], exp_p);
            end
            if (exp_p) begin
                n_cmp++;
                if (grant_log[c] !== 2'((c - 2) / 3)) begin
                    n_bad++; $display("FAIL simul_grant cycle %0d: got %0d expected %0d", c, grant_log[c], (c - 2) / 3);
                end
            end
        end
        n_cmp++; if (grant_log[6] !== 2'd1) begin n_bad++; $display("FAIL simul_grant_hold: got %0d expected 1", grant_log[6]); end
        n_cmp++; if (grant_log[15] !== 2'd3) begin n_bad++; $display("FAIL simul_grant_final: got %0d expected 3", grant_log[15]); end
        n_cmp++; if (busy_log[15] !== 1'b0) begin n_bad++; $display("FAIL simul_busy_end: got %b expected 0", busy_log[15]); end
    endtask

    task automatic test_overflow();
        int np;
        int badg;
        int early;
        apply_reset();
        enable = 1'b0;
        early  = 0;
        for (int c = 0; c < 8; c++) begin
            req_pulse = 4'b0100;
            @(negedge slow_clk);
            if (pulse_slow_out) early++;
            @(posedge slow_clk);
            #1;
        end
        req_pulse = '0;
        @(negedge slow_clk);
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL ovf_disabled_pulses: got %0d expected 0", early); end
        n_cmp++; if (overflow !== 4'b0100) begin n_bad++; $display("FAIL ovf_set: got %b expected 0100", overflow); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ovf_busy: got %b expected 1", busy); end
        @(posedge slow_clk);
        #1;
        req_pulse = 4'b0100;
        ovf_clr   = 1'b1;
        @(posedge slow_clk);
        #1;
        req_pulse = '0;
        ovf_clr   = 1'b0;
        @(negedge slow_clk);
        n_cmp++; if (overflow !== 4'b0100) begin n_bad++; $display("FAIL ovf_clr_vs_set: got %b expected 0100", overflow); end
        @(posedge slow_clk);
        #1;
        ovf_clr = 1'b1;
        @(posedge slow_clk);
        #1;
        ovf_clr = 1'b0;
        @(negedge slow_clk);
        n_cmp++; if (overflow !== 4'b0000) begin n_bad++; $display("FAIL ovf_clr: got %b expected 0000", overflow); end
        @(posedge slow_clk);
        #1;
        enable = 1'b1;
        np     = 0;
        badg   = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge slow_clk);
            if (pulse_slow_out) begin
                np++;
                if (grant_id !== 2'd2) badg++;
            end
            @(posedge slow_clk);
            #1;
        end
        n_cmp++; if (np !== 7) begin n_bad++; $display("FAIL ovf_drain_count: got %0d expected 7", np); end
        n_cmp++; if (badg !== 0) begin n_bad++; $display("FAIL ovf_drain_grant: got %0d wrong grants expected 0", badg); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovf_drain_busy: got %b expected 0", busy); end
    endtask

    task automatic test_fairness();
        int  after;
        int  n_at;
        logic seen;
        apply_reset();
        after = 0;
        n_at  = 0;
        seen  = 1'b0;
        for (int c = 0; c < 30; c++) begin
            req_pulse = (c == 6) ? 4'b1001 : 4'b0001;
            @(negedge slow_clk);
            if (pulse_slow_out && c >= 7) begin
                after++;
                if (grant_id == 2'd3 && !seen) begin
                    seen = 1'b1;
                    n_at = after;
                end
            end
            @(posedge slow_clk);
            #1;
        end
        req_pulse = '0;
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL fair_seen: got %b expected 1", seen); end
        n_cmp++; if (!(n_at >= 1 && n_at <= 2)) begin n_bad++; $display("FAIL fair_latency: got %0d pulses expected 1..2", n_at); end
        n_cmp++; if (overflow !== 4'b0001) begin n_bad++; $display("FAIL fair_overflow: got %b expected 0001", overflow); end
    endtask

    task automatic test_reset_gap();
        int np;
        apply_reset();
        req_pulse = 4'b0110;
        @(posedge slow_clk);
        #1;
        req_pulse = '0;
        @(posedge slow_clk);
        #1;
        @(negedge slow_clk);
        n_cmp++; if (pulse_slow_out !== 1'b1 || grant_id !== 2'd1) begin
            n_bad++; $display("FAIL rgap_pre_pulse: got pulse %b grant %0d expected pulse 1 grant 1", pulse_slow_out, grant_id);
        end
        @(posedge slow_clk);
        #5;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL rgap_grant: got %0d expected 0", grant_id); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rgap_busy: got %b expected 0", busy); end
        n_cmp++; if (pulse_slow_out !== 1'b0) begin n_bad++; $display("FAIL rgap_pulse: got %b expected 0", pulse_slow_out); end
        n_cmp++; if (overflow !== 4'b0000) begin n_bad++; $display("FAIL rgap_overflow: got %b expected 0000", overflow); end
        @(posedge slow_clk);
        #1;
        rst_n = 1'b1;
        np = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge slow_clk);
            if (pulse_slow_out) np++;
        end
        n_cmp++; if (np !== 0) begin n_bad++; $display("FAIL rgap_backlog: got %0d pulses expected 0", np); end
    endtask

    task automatic test_sync();
        int f0;
        int ns;
        apply_reset();
        f0 = fast_cnt;
        ns = 0;
        req_pulse = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            @(negedge slow_clk);
            if (pulse_slow_out) ns++;
            @(posedge slow_clk);
            #1;
            req_pulse = '0;
        end
        #100;
        n_cmp++; if (ns !== 4) begin n_bad++; $display("FAIL sync_slow_pulses: got %0d expected 4", ns); end
        n_cmp++; if (fast_cnt - f0 !== 4) begin n_bad++; $display("FAIL sync_fast_pulses: got %0d expected 4", fast_cnt - f0); end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_pulse = '0;
        enable    = 1'b0;
        ovf_clr   = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_overflow();
        test_fairness();
        test_reset_gap();
        test_sync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
